// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: function codes
// and the sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
           (func == FUNC_DIV)  || (func == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned 32x32 shift-add multiplier / restoring divider, one step per enable.
// acc holds {product_hi, multiplier/product_lo} or {remainder, quotient}.
module muldiv_iter (
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic        en,
  input  logic        div_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc_next
);

  logic [63:0] acc_reg;
  logic [31:0] opnd_reg;
  logic        div_reg;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    sum      = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    shifted  = acc_reg[63:31];
    diff     = shifted - {1'b0, opnd_reg};
    acc_next = {sum, acc_reg[31:1]};
    if (div_reg) begin
      // Restore (keep the shifted remainder) whenever the trial subtract borrows.
      if (!diff[32]) acc_next = {diff[31:0], acc_reg[30:0], 1'b1};
      else           acc_next = {shifted[31:0], acc_reg[30:0], 1'b0};
    end
  end

  always_ff @(negedge clk) begin
    if (!clrn) begin
      acc_reg  <= 64'd0;
      opnd_reg <= 32'd0;
      div_reg  <= 1'b0;
    end else if (load) begin
      acc_reg  <= {32'd0, div_in ? a : b};
      opnd_reg <= div_in ? b : a;
      div_reg  <= div_in;
    end else if (en) begin
      acc_reg  <= acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: decodes mul/div/MF/MT, owns HI/LO and
// stalls the pipeline for the 33 cycles an operation takes.
module ex_muldiv
  import mips_pkg::*;
(
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] EX_busA,
  input  logic [31:0] EX_busB,
  input  logic [5:0]  EX_func,
  input  logic        EX_R_type,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out,
  output logic        MD_use
);

  md_state_t   state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;

  logic        is_md, is_signed, is_div, start;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc_next, prod;
  logic [31:0] quot, rem, res_hi, res_lo;

  assign is_md     = EX_R_type && is_muldiv(EX_func);
  assign is_signed = (EX_func == FUNC_MULT) || (EX_func == FUNC_DIV);
  assign is_div    = EX_func[1];
  assign neg_a     = is_signed && EX_busA[31];
  assign neg_b     = is_signed && EX_busB[31];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a     = neg_a ? -EX_busA : EX_busA;
  assign mag_b     = neg_b ? -EX_busB : EX_busB;
  assign start     = (state_reg == IDLE) && is_md;

  assign Stall  = Clrn && (start || (state_reg == BUSY));
  assign HI     = hi_reg;
  assign LO     = lo_reg;
  assign MD_use = EX_R_type && ((EX_func == FUNC_MFHI) || (EX_func == FUNC_MFLO));

  always_comb begin
    MD_out = 32'd0;
    if (EX_R_type && (EX_func == FUNC_MFHI)) MD_out = hi_reg;
    if (EX_R_type && (EX_func == FUNC_MFLO)) MD_out = lo_reg;
  end

  muldiv_iter u_iter (
    .clk      (Clk),
    .clrn     (Clrn),
    .load     (start),
    .en       (state_reg == BUSY),
    .div_in   (is_div),
    .a        (mag_a),
    .b        (mag_b),
    .acc_next (acc_next)
  );

  always_comb begin
    prod   = neg_res_reg ? -acc_next : acc_next;
    quot   = neg_res_reg ? -acc_next[31:0] : acc_next[31:0];
    rem    = neg_rem_reg ? -acc_next[63:32] : acc_next[63:32];
    res_hi = div_reg ? rem : prod[63:32];
    res_lo = div_reg ? quot : prod[31:0];
    // Remainder already restores the original dividend; only the quotient is pinned.
    if (div_reg && div_zero_reg) res_lo = 32'hFFFF_FFFF;
  end

  always_ff @(negedge Clk) begin
    if (!Clrn) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      div_reg      <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_md) begin
            div_reg      <= is_div;
            neg_res_reg  <= neg_a ^ neg_b;
            neg_rem_reg  <= neg_a;
            div_zero_reg <= (EX_busB == 32'd0);
            cnt_reg      <= 5'd0;
            state_reg    <= BUSY;
          end else if (EX_R_type && (EX_func == FUNC_MTHI)) begin
            hi_reg <= EX_busA;
          end else if (EX_R_type && (EX_func == FUNC_MTLO)) begin
            lo_reg <= EX_busA;
          end
        end
        BUSY: begin
          if (cnt_reg == 5'd31) begin
            hi_reg    <= res_hi;
            lo_reg    <= res_lo;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases, MT/MF, reset abort,
// then random mul/div ops against a plain-arithmetic reference model.
module tb_ex_muldiv;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic [31:0] EX_busA = 32'd0;
  logic [31:0] EX_busB = 32'd0;
  logic [5:0]  EX_func = 6'd0;
  logic        EX_R_type = 1'b0;
  logic        Stall;
  logic [31:0] HI, LO, MD_out;
  logic        MD_use;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .EX_busA   (EX_busA),
    .EX_busB   (EX_busB),
    .EX_func   (EX_func),
    .EX_R_type (EX_R_type),
    .Stall     (Stall),
    .HI        (HI),
    .LO        (LO),
    .MD_out    (MD_out),
    .MD_use    (MD_use)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Reference: returns {HI, LO} from ordinary 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r, p;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      6'h18: begin p = sa * sb; return p; end
      6'h19: return ua * ub;
      6'h1A: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    int          guard;
    logic [63:0] exp;
    @(posedge Clk);
    EX_R_type = 1'b1; EX_func = f; EX_busA = a; EX_busB = b;
    #1;
    stalls = 0;
    guard  = 0;
    while (Stall && guard < 40) begin
      stalls++;
      guard++;
      @(posedge Clk);
      #1;
    end
    exp = model(f, a, b);
    $display("op %s f=%h a=%h b=%h", tag, f, a, b);
    check({tag, "_stalls"}, stalls, 32'd33);
    check({tag, "_hi"}, HI, exp[63:32]);
    check({tag, "_lo"}, LO, exp[31:0]);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    logic [5:0]  f;

    repeat (2) @(posedge Clk);
    #1;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(posedge Clk);
    Clrn = 1'b1;

    run_md("multu_ff", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("mult_m3x5", 6'h18, 32'hFFFF_FFFD, 32'd5);
    run_md("div_m7d2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divu_z", 6'h1B, 32'h64, 32'd0);
    run_md("div_negz", 6'h1A, 32'hFFFF_FFF0, 32'd0);

    // MTHI then MFHI on the next cycle
    @(posedge Clk);
    EX_R_type = 1'b1; EX_func = 6'h11; EX_busA = 32'h1234; EX_busB = 32'd0;
    #1;
    check("mthi_stall", {31'd0, Stall}, 32'd0);
    @(posedge Clk);
    EX_func = 6'h10; EX_busA = $urandom;
    #1;
    check("mfhi_out", MD_out, 32'h1234);
    check("mfhi_use", {31'd0, MD_use}, 32'd1);
    check("mfhi_stall", {31'd0, Stall}, 32'd0);

    v = $urandom | 32'h1;
    @(posedge Clk);
    EX_func = 6'h13; EX_busA = v;
    @(posedge Clk);
    EX_func = 6'h12; EX_busA = 32'd0;
    #1;
    check("mflo_out", MD_out, v);
    @(posedge Clk);
    EX_R_type = 1'b0;
    #1;
    check("nop_mdout", MD_out, 32'd0);
    check("nop_mduse", {31'd0, MD_use}, 32'd0);

    // Abort a MULT on BUSY iteration 10
    @(posedge Clk);
    EX_R_type = 1'b1; EX_func = 6'h18; EX_busA = 32'h1234_5678; EX_busB = 32'h9ABC_DEF0;
    repeat (11) @(posedge Clk);
    Clrn = 1'b0;
    #1;
    check("abort_stall_lo", {31'd0, Stall}, 32'd0);
    @(posedge Clk);
    Clrn = 1'b1; EX_R_type = 1'b0;
    #1;
    check("abort_stall", {31'd0, Stall}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    run_md("multu_6x7", 6'h19, 32'd6, 32'd7);

    for (int i = 0; i < 24; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      run_md($sformatf("rnd%0d", i), f, pick_operand(), pick_operand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
